// File: rtl/kyber_keygen_sched_pkg.sv
// Shared definitions for the Baby Kyber key-generation datapath.
// Holds the scheme constants (rank K, degree N, modulus Q), the signed
// coefficient width, the coefficient/polynomial types and the scheduler
// state encoding. It has no ports.
package kyber_pkg;

  localparam int K      = 2;
  localparam int N      = 4;
  localparam int Q      = 17;
  localparam int COEF_W = 32;

  // A row/column selector needs at least one bit, even when K is 1.
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [N-1:0]            poly_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/kyber_keygen_sched_if.sv
// Request/grant/response link between the key-generation sequencer and the
// shared polynomial multiplier (with its external A/s operand mux).
//   mul_req        sequencer -> mult  : request one product
//   mul_row/col    sequencer -> mult  : operand selectors A[row][col], s[col]
//   mul_gnt        mult -> sequencer  : request accepted
//   mul_rsp_valid  mult -> sequencer  : product coefficients valid
//   mul_rsp        mult -> sequencer  : N signed, unreduced coefficients
// master = sequencer side, slave = multiplier side.
interface kyber_keygen_sched_if;
  import kyber_pkg::*;

  logic             mul_req;
  logic [IDX_W-1:0] mul_row;
  logic [IDX_W-1:0] mul_col;
  logic             mul_gnt;
  logic             mul_rsp_valid;
  poly_t            mul_rsp;

  modport master (
    output mul_req, mul_row, mul_col,
    input  mul_gnt, mul_rsp_valid, mul_rsp
  );

  modport slave (
    input  mul_req, mul_row, mul_col,
    output mul_gnt, mul_rsp_valid, mul_rsp
  );

endinterface

// File: rtl/kyber_keygen_sched_coeff_mod_reduce.sv
// coeff_mod_reduce: combinational signed reduction of one coefficient into
// [0, Q-1], i.e. ((x % Q) + Q) % Q.
//   x  in  W signed : coefficient to reduce
//   r  out W signed : reduced value, always in [0, Q-1]
module coeff_mod_reduce #(
  parameter int W = 32,
  parameter int Q = 17
) (
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] r
);

  localparam logic signed [W-1:0] QV = W'(Q);

  logic signed [W-1:0] rem;

  // The remainder truncates toward zero, so a negative input leaves a
  // remainder in (-Q, 0) that one addition of Q brings into range.
  always_comb begin
    rem = x % QV;
    r   = (rem < 0) ? rem + QV : rem;
  end

endmodule

// File: rtl/kyber_keygen_sched.sv
// kyber_keygen_sched: computes t = A*s + e for Baby Kyber key generation
// with one shared multiplier. Each row issues K products A[r][c]*s[c],
// accumulates the signed responses, reduces mod Q, adds e[r], reduces again
// and writes t[r].
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin a computation (only honoured in IDLE)
//   abort        synchronous cancel from any state, no done pulse
//   e_in         K x N signed error coefficients, stable start..done
//   mul_if       request/grant/response link to the shared multiplier
//   busy         high in every state except IDLE
//   done         one-cycle pulse when all rows of t are written
//   t_out        K x N result coefficients in [0, Q-1]
//   proto_err    sticky flag: response seen outside WAIT
module kyber_keygen_sched
  import kyber_pkg::*;
#(
  parameter int K      = kyber_pkg::K,
  parameter int N      = kyber_pkg::N,
  parameter int Q      = kyber_pkg::Q,
  parameter int COEF_W = kyber_pkg::COEF_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic signed [K-1:0][N-1:0][COEF_W-1:0]  e_in,
  kyber_keygen_sched_if.master                    mul_if,
  output logic                                    busy,
  output logic                                    done,
  output logic        [K-1:0][N-1:0][COEF_W-1:0]  t_out,
  output logic                                    proto_err
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  sched_state_e state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic          mul_req_q, mul_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          proto_err_q, proto_err_d;
  logic signed [COEF_W-1:0] acc_q [N];
  logic signed [COEF_W-1:0] acc_d [N];
  logic [K-1:0][N-1:0][COEF_W-1:0] t_q, t_d;

  logic signed [COEF_W-1:0] acc_mod [N];
  logic signed [COEF_W-1:0] e_sum   [N];
  logic signed [COEF_W-1:0] red     [N];

  // Reduction datapath for the current row: mod(mod(acc) + e[row]).
  for (genvar i = 0; i < N; i++) begin : g_reduce
    coeff_mod_reduce #(.W(COEF_W), .Q(Q)) u_acc_mod (
      .x (acc_q[i]),
      .r (acc_mod[i])
    );

    assign e_sum[i] = acc_mod[i] + $signed(e_in[row_q][i]);

    coeff_mod_reduce #(.W(COEF_W), .Q(Q)) u_sum_mod (
      .x (e_sum[i]),
      .r (red[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    t_d         = t_q;
    // A response is only legal while a product is outstanding.
    proto_err_d = proto_err_q | (mul_if.mul_rsp_valid && (state_q != S_WAIT));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          for (int i = 0; i < N; i++) acc_d[i] = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul_if.mul_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_if.mul_rsp_valid) begin
          for (int i = 0; i < N; i++) acc_d[i] = acc_q[i] + mul_if.mul_rsp[i];
          if (col_q != LAST_IDX) begin
            col_d   = col_q + ONE_IDX;
            state_d = S_ISSUE;
          end else begin
            state_d = S_REDUCE;
          end
        end
      end
      S_REDUCE: begin
        for (int i = 0; i < N; i++) begin
          t_d[row_q][i] = red[i];
          acc_d[i]      = '0;
        end
        col_d = '0;
        if (row_q != LAST_IDX) begin
          row_d   = row_q + ONE_IDX;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort overrides any transition, including a same-cycle start.
    if (abort) state_d = S_IDLE;

    // Outputs are registered copies of what the next state implies, so
    // mul_req has no combinational path from mul_gnt.
    mul_req_d = (state_d == S_ISSUE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mul_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
      t_q         <= '0;
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mul_req_q   <= mul_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      proto_err_q <= proto_err_d;
      t_q         <= t_d;
      for (int i = 0; i < N; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign mul_if.mul_req = mul_req_q;
  assign mul_if.mul_row = row_q;
  assign mul_if.mul_col = col_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign t_out          = t_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_kyber_keygen_sched.sv
// Bench for kyber_keygen_sched: a stub multiplier with configurable grant
// stall and response latency, a table of fixed vectors, randomized vectors
// checked against a plain-arithmetic model of t = A*s + e mod Q, and hand
// sequences for abort, stray start/response and reset during REDUCE.
module tb_kyber_keygen_sched;
  import kyber_pkg::*;

  typedef poly_t [3:0] rsp_set_t;   // products in issue order (r*K + c)
  typedef poly_t [1:0] tvec_t;

  typedef struct {
    rsp_set_t rsp;
    tvec_t    e;
    int       stall;
    int       lat;
    tvec_t    exp_t;
    int       exp_done;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic signed [1:0][3:0][31:0] e_in;
  logic busy;
  logic done;
  logic [1:0][3:0][31:0] t_out;
  logic proto_err;

  kyber_keygen_sched_if mif ();

  kyber_keygen_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .e_in      (e_in),
    .mul_if    (mif),
    .busy      (busy),
    .done      (done),
    .t_out     (t_out),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stub multiplier state
  poly_t resp_tab [4];
  int    stall_left;
  int    lat;
  int    cnt;
  bit    pending;
  int    pend_idx;
  int    nprod;
  bit    holding;
  bit    stable;
  int    hold_row;
  int    hold_col;
  int    iss_row [$];
  int    iss_col [$];
  tvec_t last_t;
  vec_t  vecs [3];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic poly_t mkpoly(input int a, input int b, input int c, input int d);
    poly_t p;
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    return p;
  endfunction

  function automatic longint modq(input longint x);
    return ((x % 17) + 17) % 17;
  endfunction

  // t[r][i] = mod(mod(sum_c A[r][c]*s[c] coefficient i) + e[r][i])
  function automatic tvec_t model_t(input rsp_set_t rsp, input tvec_t e);
    tvec_t t;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        longint s = 0;
        for (int c = 0; c < 2; c++) s += longint'($signed(rsp[r*2 + c][i]));
        t[r][i] = 32'(modq(modq(s) + longint'($signed(e[r][i]))));
      end
    end
    return t;
  endfunction

  task automatic setup(input vec_t v);
    e_in       = v.e;
    for (int p = 0; p < 4; p++) resp_tab[p] = v.rsp[p];
    stall_left = v.stall;
    lat        = v.lat;
    cnt        = 0;
    pending    = 0;
    nprod      = 0;
    holding    = 0;
    stable     = 1;
    iss_row.delete();
    iss_col.delete();
  endtask

  // One cycle of the stub multiplier, called just after each clock edge.
  task automatic mul_step();
    mif.mul_gnt       = 1'b0;
    mif.mul_rsp_valid = 1'b0;
    mif.mul_rsp       = '0;
    if (pending) begin
      if (cnt == 0) begin
        mif.mul_rsp_valid = 1'b1;
        mif.mul_rsp       = resp_tab[pend_idx];
        pending           = 0;
      end else begin
        cnt--;
      end
    end else if (mif.mul_req) begin
      if (!holding) begin
        holding  = 1;
        hold_row = int'(mif.mul_row);
        hold_col = int'(mif.mul_col);
      end else if (int'(mif.mul_row) != hold_row || int'(mif.mul_col) != hold_col) begin
        stable = 0;
      end
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        mif.mul_gnt = 1'b1;
        iss_row.push_back(int'(mif.mul_row));
        iss_col.push_back(int'(mif.mul_col));
        pend_idx = nprod % 4;
        nprod++;
        pending  = 1;
        cnt      = lat;
        holding  = 0;
      end
    end
  endtask

  task automatic run_job(input vec_t v, input bit mid_start, input bit exp_proto, input string tag);
    int  n;
    int  dc;
    bit  ok;
    setup(v);
    start = 1'b1;
    n  = 0;
    dc = -1;
    while (dc < 0 && n < 300) begin
      tick();
      n++;
      start = (mid_start && n == 4);
      mul_step();
      if (done) dc = n;
    end
    start = 1'b0;
    chk({tag, ".done_cycle"}, 256'(dc), 256'(v.exp_done));
    chk({tag, ".t0"}, 256'(t_out[0]), 256'(v.exp_t[0]));
    chk({tag, ".t1"}, 256'(t_out[1]), 256'(v.exp_t[1]));
    ok = (iss_row.size() == 4);
    for (int p = 0; p < 4 && ok; p++)
      if (iss_row[p] != p / 2 || iss_col[p] != p % 2) ok = 0;
    chk({tag, ".issue_order"}, 256'(ok), 256'(1));
    chk({tag, ".rowcol_stable"}, 256'(stable), 256'(1));
    chk({tag, ".proto_err"}, 256'(proto_err), 256'(exp_proto));
    tick();
    mul_step();
    chk({tag, ".busy_after_done"}, 256'(busy), 256'(0));
    chk({tag, ".done_one_cycle"}, 256'(done), 256'(0));
    last_t = t_out;
  endtask

  initial begin
    vec_t v;
    int   n;
    int   nd;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    e_in  = '0;
    mif.mul_gnt       = 1'b0;
    mif.mul_rsp_valid = 1'b0;
    mif.mul_rsp       = '0;
    repeat (2) tick();
    chk("reset.busy", 256'(busy), 256'(0));
    chk("reset.done", 256'(done), 256'(0));
    chk("reset.mul_req", 256'(mif.mul_req), 256'(0));
    chk("reset.proto_err", 256'(proto_err), 256'(0));
    chk("reset.t_out", 256'(t_out), 256'(0));
    rst_n = 1'b1;
    tick();

    // fixed vectors
    for (int p = 0; p < 4; p++) vecs[0].rsp[p] = mkpoly(20, -3, 0, 34);
    vecs[0].e[0]     = mkpoly(0, 0, 1, 0);
    vecs[0].e[1]     = mkpoly(0, -1, 1, 0);
    vecs[0].stall    = 0;
    vecs[0].lat      = 0;
    vecs[0].exp_t[0] = mkpoly(6, 11, 1, 0);
    vecs[0].exp_t[1] = mkpoly(6, 10, 1, 0);
    vecs[0].exp_done = 11;
    vecs[1]          = vecs[0];
    vecs[1].stall    = 3;
    vecs[1].lat      = 2;
    vecs[1].exp_done = 22;
    for (int p = 0; p < 4; p++) vecs[2].rsp[p] = mkpoly(-17, -1, -34, -18);
    vecs[2].e        = '0;
    vecs[2].stall    = 0;
    vecs[2].lat      = 0;
    vecs[2].exp_t[0] = mkpoly(0, 15, 0, 15);
    vecs[2].exp_t[1] = mkpoly(0, 15, 0, 15);
    vecs[2].exp_done = 11;

    for (int k = 0; k < 3; k++) run_job(vecs[k], 1'b0, 1'b0, $sformatf("vec%0d", k));

    // randomized vectors against the model
    for (int k = 0; k < 20; k++) begin
      for (int p = 0; p < 4; p++)
        for (int i = 0; i < 4; i++)
          v.rsp[p][i] = int'($urandom_range(2000)) - 1000;
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 4; i++)
          v.e[r][i] = int'($urandom_range(100)) - 50;
      v.stall    = int'($urandom_range(3));
      v.lat      = int'($urandom_range(2));
      v.exp_t    = model_t(v.rsp, v.e);
      v.exp_done = 11 + v.stall + 4 * v.lat;
      run_job(v, 1'b0, 1'b0, $sformatf("rand%0d", k));
    end

    // abort while waiting for product (1,0)
    setup(vecs[2]);
    start = 1'b1;
    n = 0;
    while (nprod < 3 && n < 100) begin
      tick();
      n++;
      start = 1'b0;
      mul_step();
    end
    chk("abort.reached_row1", 256'(nprod), 256'(3));
    tick();
    abort = 1'b1;
    mif.mul_gnt       = 1'b0;
    mif.mul_rsp_valid = 1'b0;
    pending = 0;
    tick();
    abort = 1'b0;
    chk("abort.busy", 256'(busy), 256'(0));
    chk("abort.mul_req", 256'(mif.mul_req), 256'(0));
    chk("abort.done", 256'(done), 256'(0));
    chk("abort.t0_written", 256'(t_out[0]), 256'(vecs[2].exp_t[0]));
    chk("abort.t1_kept", 256'(t_out[1]), 256'(last_t[1]));
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      mul_step();
      if (done || mif.mul_req || busy) nd++;
    end
    chk("abort.quiet", 256'(nd), 256'(0));
    run_job(vecs[0], 1'b0, 1'b0, "after_abort");

    // abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start.busy", 256'(busy), 256'(0));
    chk("abort_start.mul_req", 256'(mif.mul_req), 256'(0));

    // stray response in IDLE, then a stray start during a run
    mif.mul_rsp_valid = 1'b1;
    mif.mul_rsp       = mkpoly(5, 5, 5, 5);
    tick();
    mif.mul_rsp_valid = 1'b0;
    mif.mul_rsp       = '0;
    chk("stray_rsp.proto_err", 256'(proto_err), 256'(1));
    tick();
    chk("stray_rsp.sticky", 256'(proto_err), 256'(1));
    run_job(vecs[1], 1'b1, 1'b1, "mid_start");

    // reset asserted while row 0 is in REDUCE
    setup(vecs[0]);
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      start = 1'b0;
      mul_step();
    end
    rst_n = 1'b0;
    mif.mul_gnt       = 1'b0;
    mif.mul_rsp_valid = 1'b0;
    tick();
    chk("rst_reduce.busy", 256'(busy), 256'(0));
    chk("rst_reduce.done", 256'(done), 256'(0));
    chk("rst_reduce.mul_req", 256'(mif.mul_req), 256'(0));
    chk("rst_reduce.proto_err", 256'(proto_err), 256'(0));
    chk("rst_reduce.t_out", 256'(t_out), 256'(0));
    rst_n = 1'b1;
    tick();
    run_job(vecs[2], 1'b0, 1'b0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
